// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, default line settings
// and the sample-tick divisor used by both RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
  localparam int unsigned DEF_BAUD      = 115200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  function automatic int unsigned calc_tick_div(
    input int unsigned clk_freq,
    input int unsigned baud,
    input int unsigned oversample
  );
    int unsigned rate;
    rate = baud * oversample;
    return (clk_freq + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Sample-tick generator: one-cycle tick every DIV clocks,
// re-phased to zero by restart.
module baud_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("baud_tick_gen: DIV must be >= 1");
    end
  endgenerate

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Debug UART receiver: 2-flop synchroniser, oversampled 8N1 framing
// with 3-sample majority vote, single-entry ready/valid output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned TICK_DIV =
    calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S0_IDX  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S1_IDX  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] DEC_IDX = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] LAST    = SW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;
  localparam logic [2:0] S_BREAK = BREAK;

  generate
    if (TICK_DIV < 1) begin : g_bad_div
      $error("uart_rx: clock too slow for BAUD*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be even and >= 8");
    end
  endgenerate

  logic [1:0]    sync;
  logic          rxs;
  logic          rxs_d;
  logic [1:0]    warm;
  logic          armed;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          s0;
  logic          s1;
  logic          tick;
  logic          fall;
  logic          restart;
  logic          decide;
  logic          bit_val;

  assign rxs     = sync[1];
  // rxs and rxs_d only hold real line samples three clocks after reset
  assign armed   = (warm == 2'd3);
  assign fall    = rxs_d & ~rxs;
  assign restart = (state == S_IDLE) && armed && fall;
  assign decide  = tick && (scnt == DEC_IDX);
  assign bit_val = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

  baud_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      rxs_d       <= 1'b1;
      warm        <= 2'd0;
      state       <= S_IDLE;
      scnt        <= '0;
      bidx        <= 3'd0;
      shreg       <= 8'd0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync        <= {sync[0], RX};
      rxs_d       <= rxs;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (!armed) begin
        warm <= warm + 2'd1;
      end
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (tick && (state != S_IDLE) && (state != S_BREAK)) begin
        scnt <= (scnt == LAST) ? '0 : scnt + 1'b1;
        if (scnt == S0_IDX) s0 <= rxs;
        if (scnt == S1_IDX) s1 <= rxs;
      end
      unique case (1'b1)
        (state == S_IDLE): begin
          if (armed) begin
            if (fall) begin
              state <= S_START;
              scnt  <= '0;
            end else if (!rxs) begin
              state <= S_BREAK;
            end
          end
        end
        (state == S_START): begin
          if (decide) begin
            state <= bit_val ? S_IDLE : S_DATA;
            bidx  <= 3'd0;
          end
        end
        (state == S_DATA): begin
          if (decide) begin
            shreg <= {bit_val, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) state <= S_STOP;
          end
        end
        (state == S_STOP): begin
          if (decide) begin
            state <= bit_val ? S_IDLE : S_BREAK;
            if (!bit_val) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
        end
        (state == S_BREAK): begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at one clock per sample tick
// (16 clocks per bit); inputs change 2 time units after posedge.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int nf = 0;
  int no = 0;
  logic [7:0] q[$];

  uart_rx #(
    .CLK_FREQ  (1_843_200),
    .BAUD      (115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) q.push_back(rx_data);
      if (frame_err) nf <= nf + 1;
      if (overrun_err) no <= no + 1;
    end
  end

  function automatic int qget(input int i);
    return (q.size() > i) ? int'(q[i]) : 32'h1ff;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    #(n * 10);
  endtask

  // bit_t is the bit period in time units; gbit selects a frame bit
  // (0 = start) that gets a 1-clock inverted glitch at its 9th clock
  task automatic send(input logic [7:0] b, input int bit_t,
                      input logic stop, input int gbit);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = f[k];
      if (k == gbit) begin
        #80;
        RX = ~f[k];
        #10;
        RX = f[k];
        #(bit_t - 90);
      end else begin
        #(bit_t);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    rx_ready = 1'b1;
    @(posedge clk);
    #2;
    idle(5);
    @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun_err", overrun_err, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(20);

    send(8'hA5, 160, 1'b1, -1);
    idle(20);
    check("a5 count", q.size(), 1);
    check("a5 data", qget(0), 8'hA5);
    check("a5 ferr", nf, 0);
    check("a5 oerr", no, 0);

    rx_ready = 1'b0;
    send(8'h12, 160, 1'b1, -1);
    send(8'h34, 160, 1'b1, -1);
    idle(20);
    @(negedge clk);
    check("ovr valid held", rx_valid, 1);
    check("ovr data held", rx_data, 8'h12);
    check("ovr oerr", no, 1);
    check("ovr none taken", q.size(), 1);
    @(posedge clk);
    #2;
    rx_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("ovr valid drop", rx_valid, 0);
    check("ovr taken", qget(1), 8'h12);
    idle(30);
    check("ovr 34 lost", q.size(), 2);

    send(8'h55, 160, 1'b0, -1);
    RX = 1'b0;
    #(40 * 160);
    RX = 1'b1;
    idle(20);
    check("brk ferr", nf, 1);
    check("brk no data", q.size(), 2);
    send(8'h3C, 160, 1'b1, -1);
    idle(20);
    check("brk 3c data", qget(2), 8'h3C);
    check("brk 3c count", q.size(), 3);
    check("brk oerr", no, 1);

    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(40);
    check("glitch no data", q.size(), 3);
    check("glitch no ferr", nf, 1);
    send(8'hFF, 160, 1'b1, 4);
    idle(20);
    check("vote ff", qget(3), 8'hFF);

    fork
      send(8'h81, 160, 1'b1, -1);
      begin
        idle(72);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
      end
    join
    idle(20);
    check("rst no data", q.size(), 4);
    check("rst no ferr", nf, 1);
    check("rst no oerr", no, 1);
    check("rst valid", rx_valid, 0);
    send(8'h7E, 160, 1'b1, -1);
    idle(20);
    check("rst 7e", qget(4), 8'h7E);

    send(8'h00, 155, 1'b1, -1);
    idle(20);
    send(8'hFF, 165, 1'b1, -1);
    idle(20);
    check("fast 00", qget(5), 8'h00);
    check("slow ff", qget(6), 8'hFF);
    check("final count", q.size(), 7);
    check("final ferr", nf, 1);
    check("final oerr", no, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
